seq_progress_checker: RTL and testbench

- Downstream monitor for the five-step start/ready sequencer.
- Watches the sequencer's registered state code, ready flag and start input, and checks that each step is legal.
- Measures run length in cycles and steps, pulses done when the run completes, and latches a sticky error code on the first violation.
- Sits beside the sequencer in the control path and feeds status logic.

---
 rtl/seq_progress_checker.sv | 166 ++++++++++++++++
 tb/tb_seq_progress_checker.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/seq_progress_checker.sv
// Monitor for the five-step start/ready sequencer: checks each step for legality,
// measures run length and latches the first violation as a sticky error code.
module seq_progress_checker #(
  parameter int unsigned CODE_W    = 5,
  parameter int unsigned LAST_CODE = 4,
  parameter int unsigned CNT_W     = 12,
  parameter int unsigned MAX_STALL = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              seq_start,
  input  logic [CODE_W-1:0] seq_code,
  input  logic              seq_ready,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [2:0]        err_code,
  output logic [CODE_W-1:0] step_count,
  output logic [CNT_W-1:0]  cycle_count
);

  localparam int unsigned STALL_W = $clog2(MAX_STALL + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_TRACK = 2'd1,
    S_DONE  = 2'd2,
    S_ERROR = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [CODE_W-1:0]   prev_code_q, prev_code_d;
  logic                prev_start_q, prev_start_d;
  logic [STALL_W-1:0]  stall_q, stall_d;
  logic [CODE_W-1:0]   step_q, step_d;
  logic [CNT_W-1:0]    cyc_q, cyc_d;
  logic [2:0]          err_code_q, err_code_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                error_q, error_d;

  logic [CODE_W:0]     code_ext;
  logic [CODE_W:0]     prev_inc;
  logic                is_last;
  logic                adv;
  logic                hold;
  logic [2:0]          viol;

  assign code_ext = {1'b0, seq_code};
  assign prev_inc = {1'b0, prev_code_q} + (CODE_W+1)'(1);
  assign is_last  = (seq_code == CODE_W'(LAST_CODE));
  assign adv      = (code_ext == prev_inc);
  assign hold     = (seq_code == prev_code_q);

  // Violation priority: lowest cause number wins.
  always_comb begin
    viol = 3'd0;
    if (seq_code > CODE_W'(LAST_CODE))               viol = 3'd1;
    else if (code_ext > prev_inc)                    viol = 3'd2;
    else if (seq_code < prev_code_q)                 viol = 3'd3;
    else if (seq_ready != is_last)                   viol = 3'd4;
    // Error on the hold cycle whose count would reach MAX_STALL.
    else if (hold && (stall_q == STALL_W'(MAX_STALL - 1))) viol = 3'd5;
    else if ((!hold && !prev_start_q) ||
             (hold && prev_start_q && (prev_code_q < CODE_W'(LAST_CODE))))
                                                     viol = 3'd6;
  end

  always_comb begin
    state_d      = state_q;
    prev_code_d  = prev_code_q;
    prev_start_d = prev_start_q;
    stall_d      = stall_q;
    step_d       = step_q;
    cyc_d        = cyc_q;
    err_code_d   = err_code_q;

    case (state_q)
      S_IDLE: begin
        if ((seq_code == '0) && seq_start) begin
          state_d      = S_TRACK;
          cyc_d        = '0;
          step_d       = '0;
          stall_d      = '0;
          prev_code_d  = '0;
          prev_start_d = 1'b1;
        end
      end
      S_TRACK: begin
        if (cyc_q != '1) cyc_d = cyc_q + CNT_W'(1);
        prev_code_d  = seq_code;
        prev_start_d = seq_start;
        if (viol != 3'd0) begin
          state_d    = S_ERROR;
          err_code_d = viol;
        end else begin
          if (adv) begin
            step_d  = step_q + CODE_W'(1);
            stall_d = '0;
          end else begin
            stall_d = stall_q + STALL_W'(1);
          end
          if (is_last && seq_ready) state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (seq_code == '0) begin
          state_d = S_IDLE;
        end else if (!is_last) begin
          state_d    = S_ERROR;
          err_code_d = 3'd3;
        end
      end
      default: ;
    endcase

    if (clear) begin
      state_d      = S_IDLE;
      prev_code_d  = '0;
      prev_start_d = 1'b0;
      stall_d      = '0;
      step_d       = '0;
      cyc_d        = '0;
      err_code_d   = 3'd0;
    end

    busy_d  = (state_d == S_TRACK);
    done_d  = (state_q == S_TRACK) && (state_d == S_DONE);
    error_d = (state_d == S_ERROR);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      prev_code_q  <= '0;
      prev_start_q <= 1'b0;
      stall_q      <= '0;
      step_q       <= '0;
      cyc_q        <= '0;
      err_code_q   <= 3'd0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      prev_code_q  <= prev_code_d;
      prev_start_q <= prev_start_d;
      stall_q      <= stall_d;
      step_q       <= step_d;
      cyc_q        <= cyc_d;
      err_code_q   <= err_code_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = error_q;
  assign err_code    = err_code_q;
  assign step_count  = step_q;
  assign cycle_count = cyc_q;

endmodule

// File: tb/tb_seq_progress_checker.sv
// Table-driven bench for seq_progress_checker with hand-written stall and reset sequences.
module tb_seq_progress_checker;

  logic        clk = 1'b0;
  logic        reset, clear, seq_start, seq_ready;
  logic [4:0]  seq_code;
  logic        busy, done, error;
  logic [2:0]  err_code;
  logic [4:0]  step_count;
  logic [11:0] cycle_count;

  int passed = 0;
  int total  = 0;

  typedef struct packed {
    logic        clr;
    logic        st;
    logic [4:0]  code;
    logic        rdy;
    logic        busy;
    logic        done;
    logic        err;
    logic [2:0]  ec;
    logic [4:0]  step;
    logic [11:0] cyc;
  } vec_t;

  vec_t tbl[$];

  seq_progress_checker #(.CODE_W(5), .LAST_CODE(4), .CNT_W(12), .MAX_STALL(255)) dut (
    .clk(clk), .reset(reset), .clear(clear), .seq_start(seq_start),
    .seq_code(seq_code), .seq_ready(seq_ready), .busy(busy), .done(done),
    .error(error), .err_code(err_code), .step_count(step_count),
    .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input int clr, input int st, input int code, input int rdy,
                              input int b, input int d, input int e, input int ec,
                              input int step, input int cyc);
    vec_t v;
    v.clr = 1'(clr); v.st = 1'(st); v.code = 5'(code); v.rdy = 1'(rdy);
    v.busy = 1'(b); v.done = 1'(d); v.err = 1'(e); v.ec = 3'(ec);
    v.step = 5'(step); v.cyc = 12'(cyc);
    return v;
  endfunction

  task automatic chk(input string name, input logic b, input logic d, input logic e,
                     input logic [2:0] ec, input logic [4:0] st, input logic [11:0] cy);
    logic [22:0] act, exp;
    act = {busy, done, error, err_code, step_count, cycle_count};
    exp = {b, d, e, ec, st, cy};
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got busy=%0b done=%0b error=%0b err_code=%0d step=%0d cycle=%0d, expected busy=%0b done=%0b error=%0b err_code=%0d step=%0d cycle=%0d",
                  name, busy, done, error, err_code, step_count, cycle_count, b, d, e, ec, st, cy);
  endtask

  task automatic cyc(input logic clr, input logic st, input logic [4:0] code, input logic rdy);
    clear = clr; seq_start = st; seq_code = code; seq_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; seq_start = 1'b0; seq_code = '0; seq_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("reset", 0, 0, 0, 0, 0, 0);
    reset = 1'b0;

    // clr st code rdy | busy done err ec step cyc
    // clean run, start held high
    tbl.push_back(mk(0,1,0,0, 1,0,0,0,0,0));
    tbl.push_back(mk(0,1,1,0, 1,0,0,0,1,1));
    tbl.push_back(mk(0,1,2,0, 1,0,0,0,2,2));
    tbl.push_back(mk(0,1,3,0, 1,0,0,0,3,3));
    tbl.push_back(mk(0,1,4,1, 0,1,0,0,4,4));
    tbl.push_back(mk(0,0,4,1, 0,0,0,0,4,4));
    tbl.push_back(mk(0,0,0,0, 0,0,0,0,4,4));
    // alternating start
    tbl.push_back(mk(0,1,0,0, 1,0,0,0,0,0));
    tbl.push_back(mk(0,0,1,0, 1,0,0,0,1,1));
    tbl.push_back(mk(0,1,1,0, 1,0,0,0,1,2));
    tbl.push_back(mk(0,0,2,0, 1,0,0,0,2,3));
    tbl.push_back(mk(0,1,2,0, 1,0,0,0,2,4));
    tbl.push_back(mk(0,0,3,0, 1,0,0,0,3,5));
    tbl.push_back(mk(0,1,3,0, 1,0,0,0,3,6));
    tbl.push_back(mk(0,0,4,1, 0,1,0,0,4,7));
    tbl.push_back(mk(0,0,0,0, 0,0,0,0,4,7));
    // skipped step, sticky cause, clear beats IDLE start
    tbl.push_back(mk(0,1,0,0, 1,0,0,0,0,0));
    tbl.push_back(mk(0,1,1,0, 1,0,0,0,1,1));
    tbl.push_back(mk(0,1,3,0, 0,0,1,2,1,2));
    tbl.push_back(mk(0,1,7,1, 0,0,1,2,1,2));
    tbl.push_back(mk(1,1,0,0, 0,0,0,0,0,0));
    // ready mismatch
    tbl.push_back(mk(0,1,0,0, 1,0,0,0,0,0));
    tbl.push_back(mk(0,1,1,0, 1,0,0,0,1,1));
    tbl.push_back(mk(0,1,2,0, 1,0,0,0,2,2));
    tbl.push_back(mk(0,1,3,1, 0,0,1,4,2,3));
    tbl.push_back(mk(1,0,0,0, 0,0,0,0,0,0));
    // illegal code outranks ready mismatch
    tbl.push_back(mk(0,1,0,0, 1,0,0,0,0,0));
    tbl.push_back(mk(0,1,1,0, 1,0,0,0,1,1));
    tbl.push_back(mk(0,1,2,0, 1,0,0,0,2,2));
    tbl.push_back(mk(0,1,7,1, 0,0,1,1,2,3));
    tbl.push_back(mk(1,0,0,0, 0,0,0,0,0,0));
    // bad code while DONE
    tbl.push_back(mk(0,1,0,0, 1,0,0,0,0,0));
    tbl.push_back(mk(0,1,1,0, 1,0,0,0,1,1));
    tbl.push_back(mk(0,1,2,0, 1,0,0,0,2,2));
    tbl.push_back(mk(0,1,3,0, 1,0,0,0,3,3));
    tbl.push_back(mk(0,1,4,1, 0,1,0,0,4,4));
    tbl.push_back(mk(0,0,2,0, 0,0,1,3,4,4));
    tbl.push_back(mk(1,0,0,0, 0,0,0,0,0,0));
    // advance without start
    tbl.push_back(mk(0,1,0,0, 1,0,0,0,0,0));
    tbl.push_back(mk(0,0,1,0, 1,0,0,0,1,1));
    tbl.push_back(mk(0,0,2,0, 0,0,1,6,1,2));
    tbl.push_back(mk(1,0,0,0, 0,0,0,0,0,0));
    // missed advance
    tbl.push_back(mk(0,1,0,0, 1,0,0,0,0,0));
    tbl.push_back(mk(0,1,1,0, 1,0,0,0,1,1));
    tbl.push_back(mk(0,1,1,0, 0,0,1,6,1,2));
    tbl.push_back(mk(1,0,0,0, 0,0,0,0,0,0));
    // backward step
    tbl.push_back(mk(0,1,0,0, 1,0,0,0,0,0));
    tbl.push_back(mk(0,1,1,0, 1,0,0,0,1,1));
    tbl.push_back(mk(0,1,2,0, 1,0,0,0,2,2));
    tbl.push_back(mk(0,1,1,0, 0,0,1,3,2,3));
    tbl.push_back(mk(1,0,0,0, 0,0,0,0,0,0));
    // nonzero code in IDLE ignored
    tbl.push_back(mk(0,1,2,0, 0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0, 0,0,0,0,0,0));

    foreach (tbl[i]) begin
      cyc(tbl[i].clr, tbl[i].st, tbl[i].code, tbl[i].rdy);
      chk($sformatf("vec%0d", i), tbl[i].busy, tbl[i].done, tbl[i].err,
          tbl[i].ec, tbl[i].step, tbl[i].cyc);
    end

    // 255 consecutive holds trip the stall timeout
    cyc(0, 1, 5'd0, 0);
    cyc(0, 1, 5'd1, 0);
    cyc(0, 0, 5'd2, 0);
    chk("stall_pre", 1, 0, 0, 0, 2, 2);
    for (int k = 1; k <= 254; k++) cyc(0, 0, 5'd2, 0);
    chk("stall_254", 1, 0, 0, 0, 2, 256);
    cyc(0, 0, 5'd2, 0);
    chk("stall_255", 0, 0, 1, 5, 2, 257);
    cyc(1, 0, 5'd0, 0);
    chk("stall_clear", 0, 0, 0, 0, 0, 0);

    // 254 holds then an advance is legal
    cyc(0, 1, 5'd0, 0);
    cyc(0, 1, 5'd1, 0);
    cyc(0, 0, 5'd2, 0);
    for (int k = 1; k <= 253; k++) cyc(0, 0, 5'd2, 0);
    cyc(0, 1, 5'd2, 0);
    chk("hold_254", 1, 0, 0, 0, 2, 256);
    cyc(0, 1, 5'd3, 0);
    chk("hold_adv", 1, 0, 0, 0, 3, 257);
    cyc(0, 1, 5'd4, 1);
    chk("hold_done", 0, 1, 0, 0, 4, 258);
    cyc(0, 0, 5'd0, 0);

    // reset mid-run, then a fresh clean run
    cyc(0, 1, 5'd0, 0);
    cyc(0, 1, 5'd1, 0);
    cyc(0, 1, 5'd2, 0);
    chk("mid_pre", 1, 0, 0, 0, 2, 2);
    reset = 1'b1;
    cyc(1, 1, 5'd3, 0);
    chk("mid_reset", 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    cyc(0, 1, 5'd0, 0);
    chk("rerun_start", 1, 0, 0, 0, 0, 0);
    for (int c = 1; c <= 3; c++) cyc(0, 1, 5'(c), 0);
    cyc(0, 1, 5'd4, 1);
    chk("rerun_done", 0, 1, 0, 0, 4, 4);
    cyc(0, 0, 5'd4, 1);
    chk("rerun_hold", 0, 0, 0, 0, 4, 4);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
